// File: rtl/inst_ram_loader_if.sv
// Byte-stream input and instruction-RAM write port of the boot loader.
// Both groups share one bundle: the loader consumes bytes and drives the RAM.
interface inst_ram_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;

    // Master is the byte source and RAM observer; the loader is the slave.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ram_we,
        output ram_addr,
        output ram_wdata
    );
endinterface

// File: rtl/inst_ram_loader.sv
// Boot loader: receives a length-prefixed little-endian byte frame, writes words to
// instruction RAM, verifies an XOR checksum and then releases the CPU from reset.
module inst_ram_loader #(
    parameter int DEPTH_W = 10          // supported range 1..16 (length field is 16 bits)
) (
    input  logic                 clk,
    input  logic                 rstn,
    inst_ram_loader_if.slave     bus,
    input  logic                 reload,
    output logic                 load_active,
    output logic                 cpu_rstn,
    output logic                 done,
    output logic [1:0]           err_code
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    // Counter is one bit wider than the length field so N = 2^16 style bounds still compare.
    localparam int                 CNT_W     = 17;
    localparam logic [CNT_W-1:0]   MAX_WORDS = CNT_W'(1) << DEPTH_W;
    localparam logic [1:0]         ERR_NONE  = 2'd0;
    localparam logic [1:0]         ERR_LEN   = 2'd1;
    localparam logic [1:0]         ERR_CSUM  = 2'd2;

    state_t              state_reg, state_next;
    logic [15:0]         len_reg, len_next;
    logic [CNT_W-1:0]    word_idx_reg, word_idx_next;
    logic [1:0]          byte_idx_reg, byte_idx_next;
    logic [7:0]          csum_reg, csum_next;
    logic                in_ready_reg, in_ready_next;
    logic                ram_we_reg, ram_we_next;
    logic [31:0]         ram_addr_reg, ram_addr_next;
    logic [31:0]         ram_wdata_reg, ram_wdata_next;
    logic                load_active_reg, load_active_next;
    logic                cpu_rstn_reg, cpu_rstn_next;
    logic                done_reg, done_next;
    logic [1:0]          err_code_reg, err_code_next;

    logic                hs;
    logic [15:0]         len_full;
    logic [CNT_W-1:0]    word_idx_inc;
    logic [2:0]          lane_we;
    logic [23:0]         asm_word;

    assign hs           = bus.in_valid & in_ready_reg;
    assign len_full     = {bus.in_data, len_reg[7:0]};
    assign word_idx_inc = word_idx_reg + CNT_W'(1);

    // Lower three bytes of a word are parked in per-lane registers; the fourth
    // byte goes straight into the output word, so no extra cycle is spent.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    lane_reg <= '0;
                end else if (lane_we[gi]) begin
                    lane_reg <= bus.in_data;
                end
            end
            assign asm_word[8*gi +: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= S_LEN0;
            len_reg         <= '0;
            word_idx_reg    <= '0;
            byte_idx_reg    <= '0;
            csum_reg        <= '0;
            in_ready_reg    <= 1'b1;
            ram_we_reg      <= 1'b0;
            ram_addr_reg    <= '0;
            ram_wdata_reg   <= '0;
            load_active_reg <= 1'b1;
            cpu_rstn_reg    <= 1'b0;
            done_reg        <= 1'b0;
            err_code_reg    <= ERR_NONE;
        end else begin
            state_reg       <= state_next;
            len_reg         <= len_next;
            word_idx_reg    <= word_idx_next;
            byte_idx_reg    <= byte_idx_next;
            csum_reg        <= csum_next;
            in_ready_reg    <= in_ready_next;
            ram_we_reg      <= ram_we_next;
            ram_addr_reg    <= ram_addr_next;
            ram_wdata_reg   <= ram_wdata_next;
            load_active_reg <= load_active_next;
            cpu_rstn_reg    <= cpu_rstn_next;
            done_reg        <= done_next;
            err_code_reg    <= err_code_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        len_next         = len_reg;
        word_idx_next    = word_idx_reg;
        byte_idx_next    = byte_idx_reg;
        csum_next        = csum_reg;
        ram_we_next      = 1'b0;
        ram_addr_next    = ram_addr_reg;
        ram_wdata_next   = ram_wdata_reg;
        load_active_next = load_active_reg;
        cpu_rstn_next    = cpu_rstn_reg;
        done_next        = done_reg;
        err_code_next    = err_code_reg;
        lane_we          = '0;

        case (state_reg)
            S_LEN0: begin
                if (hs) begin
                    len_next[7:0] = bus.in_data;
                    state_next    = S_LEN1;
                end
            end

            S_LEN1: begin
                if (hs) begin
                    len_next      = len_full;
                    word_idx_next = '0;
                    byte_idx_next = '0;
                    csum_next     = '0;
                    if ({1'b0, len_full} > MAX_WORDS) begin
                        err_code_next = ERR_LEN;
                        state_next    = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_next    = S_CSUM;
                    end else begin
                        state_next    = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (hs) begin
                    csum_next     = csum_reg ^ bus.in_data;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        ram_wdata_next = {bus.in_data, asm_word};
                        ram_addr_next  = 32'(word_idx_reg);
                        ram_we_next    = 1'b1;
                        word_idx_next  = word_idx_inc;
                        if (word_idx_inc == {1'b0, len_reg}) begin
                            state_next = S_CSUM;
                        end
                    end else begin
                        lane_we = 3'b001 << byte_idx_reg;
                    end
                end
            end

            S_CSUM: begin
                if (hs) begin
                    if (bus.in_data == csum_reg) begin
                        cpu_rstn_next    = 1'b1;
                        done_next        = 1'b1;
                        load_active_next = 1'b0;
                        state_next       = S_RUN;
                    end else begin
                        err_code_next    = ERR_CSUM;
                        state_next       = S_ERR;
                    end
                end
            end

            S_RUN, S_ERR: begin
                // Restart drops the CPU back into reset on the same edge.
                if (reload) begin
                    state_next       = S_LEN0;
                    len_next         = '0;
                    word_idx_next    = '0;
                    byte_idx_next    = '0;
                    csum_next        = '0;
                    cpu_rstn_next    = 1'b0;
                    done_next        = 1'b0;
                    load_active_next = 1'b1;
                    err_code_next    = ERR_NONE;
                end
            end

            default: begin
                state_next = S_LEN0;
            end
        endcase
    end

    assign in_ready_next = (state_next == S_LEN0) || (state_next == S_LEN1) ||
                           (state_next == S_DATA) || (state_next == S_CSUM);

    assign bus.in_ready  = in_ready_reg;
    assign bus.ram_we    = ram_we_reg;
    assign bus.ram_addr  = ram_addr_reg;
    assign bus.ram_wdata = ram_wdata_reg;
    assign load_active   = load_active_reg;
    assign cpu_rstn      = cpu_rstn_reg;
    assign done          = done_reg;
    assign err_code      = err_code_reg;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed bench for inst_ram_loader: normal, bad checksum, overflow, zero length,
// full-depth, gapped, reload and mid-load reset scenarios.
module tb_inst_ram_loader;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       reload = 1'b0;
    logic       load_active;
    logic       cpu_rstn;
    logic       done;
    logic [1:0] err_code;

    inst_ram_loader_if bus();

    inst_ram_loader #(.DEPTH_W(10)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .reload      (reload),
        .load_active (load_active),
        .cpu_rstn    (cpu_rstn),
        .done        (done),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] frame_q[$];
    int         pass_cnt = 0;
    int         total    = 0;
    int         fail_cnt = 0;

    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            got_q.push_back({bus.ram_addr, bus.ram_wdata});
            $display("write addr=%08h data=%08h", bus.ram_addr, bus.ram_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic rdy, input logic la,
                                 input logic cr, input logic dn, input logic [1:0] ec);
        check({tag, "_in_ready"},    32'(bus.in_ready), 32'(rdy));
        check({tag, "_load_active"}, 32'(load_active),  32'(la));
        check({tag, "_cpu_rstn"},    32'(cpu_rstn),     32'(cr));
        check({tag, "_done"},        32'(done),         32'(dn));
        check({tag, "_err_code"},    32'(err_code),     32'(ec));
    endtask

    task automatic compare_writes(input string tag);
        int n;
        #1;
        check({tag, "_wr_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_wr_addr"}, got_q[i].addr, exp_q[i].addr);
            check({tag, "_wr_data"}, got_q[i].data, exp_q[i].data);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Called and returns at a falling edge with in_valid low.
    task automatic send_byte(input logic [7:0] b);
        int budget;
        budget = 50;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            check("ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input int reload_at);
        for (int k = 0; k < frame_q.size(); k++) begin
            if (k == reload_at) begin
                reload = 1'b1;
                @(negedge clk);
                reload = 1'b0;
            end
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_data = 8'($urandom);
                    @(negedge clk);
                end
            end
            send_byte(frame_q[k]);
        end
        frame_q.delete();
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic push_normal_data();
        frame_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_q.push_back({32'd0, 32'h12345678});
        exp_q.push_back({32'd1, 32'hDEADBEEF});
    endtask

    initial begin
        logic [7:0] csum;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check_outputs("reset", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        check("reset_ram_we",    32'(bus.ram_we), 32'd0);
        check("reset_ram_addr",  bus.ram_addr,    32'd0);
        check("reset_ram_wdata", bus.ram_wdata,   32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Normal load; release only after the checksum byte
        push_normal_data();
        send_frame(1'b0, -1);
        check("normal_pre_csum_cpu_rstn", 32'(cpu_rstn), 32'd0);
        send_byte(8'h2A);
        check_outputs("normal", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        compare_writes("normal");

        // Bytes offered while running are not consumed
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) @(negedge clk);
        check_outputs("run_ignore", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        bus.in_valid = 1'b0;
        compare_writes("run_ignore");

        // Reload from RUN and a single-word frame
        do_reload();
        check_outputs("reload_run", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        frame_q = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        exp_q.push_back({32'd0, 32'h00000001});
        send_frame(1'b0, -1);
        check_outputs("second", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        compare_writes("second");

        // Bad checksum, with a reload pulse mid-frame that must be ignored
        do_reload();
        push_normal_data();
        frame_q.push_back(8'h2B);
        send_frame(1'b0, 5);
        check_outputs("bad_csum", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        compare_writes("bad_csum");

        // Length overflow: N = 1025
        do_reload();
        check_outputs("reload_err", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        send_byte(8'h01);
        check("ovf_first_in_ready", 32'(bus.in_ready), 32'd1);
        send_byte(8'h04);
        check_outputs("overflow", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        repeat (2) @(negedge clk);
        compare_writes("overflow");

        // Zero length
        do_reload();
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame(1'b0, -1);
        check_outputs("zero_len", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        compare_writes("zero_len");

        // Full depth: N = 1024 counting words
        do_reload();
        frame_q = '{8'h00, 8'h04};
        csum = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            frame_q.push_back(8'(i));
            frame_q.push_back(8'(i >> 8));
            frame_q.push_back(8'h00);
            frame_q.push_back(8'h00);
            csum = csum ^ 8'(i) ^ 8'(i >> 8);
            exp_q.push_back({32'(i), 32'(i)});
        end
        frame_q.push_back(csum);
        send_frame(1'b0, -1);
        check_outputs("full", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        check("full_last_addr", got_q.size() > 0 ? got_q[got_q.size()-1].addr : 32'hFFFFFFFF,
              32'h000003FF);
        compare_writes("full");

        // Normal frame with random valid gaps and junk data in the gaps
        do_reload();
        push_normal_data();
        frame_q.push_back(8'h2A);
        send_frame(1'b1, -1);
        check_outputs("gaps", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        compare_writes("gaps");

        // Reset after 5 data bytes aborts the load
        do_reload();
        frame_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_q.push_back({32'd0, 32'h44332211});
        send_frame(1'b0, -1);
        #1 rstn = 1'b0;
        #1;
        check_outputs("midrst", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        check("midrst_ram_we",    32'(bus.ram_we), 32'd0);
        check("midrst_ram_addr",  bus.ram_addr,    32'd0);
        check("midrst_ram_wdata", bus.ram_wdata,   32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        compare_writes("midrst");

        // A fresh frame loads cleanly after the abort
        frame_q = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        exp_q.push_back({32'd0, 32'h00000001});
        send_frame(1'b0, -1);
        check_outputs("post_rst", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        compare_writes("post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
